// File: rtl/ogege_pkg.sv
// rtl/ogege_pkg.sv - shared constants and types for the text fetch stage
package ogege_pkg;

    localparam int ADDR_W = 13;
    localparam int COLS_DEFAULT = 80;
    localparam int ROWS_DEFAULT = 60;

    localparam int CHAR_LSB = 0;
    localparam int FG_LSB   = 8;
    localparam int BG_LSB   = 12;

    localparam logic [15:0] CLEAR_WORD_DEFAULT = 16'h1F20;

    localparam logic [11:0] PAL_RESET_1  = 12'h008;
    localparam logic [11:0] PAL_RESET_15 = 12'hFFF;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } fetch_state_t;

    function automatic logic [11:0] palette_reset(input logic [3:0] idx);
        case (idx)
            4'd1:    return PAL_RESET_1;
            4'd15:   return PAL_RESET_15;
            default: return 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/text_ram.sv
// rtl/text_ram.sv - simple dual-port read-first cell RAM
module text_ram #(
    parameter int DEPTH = 4800,
    parameter int AW    = 13,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];

    // Reads outside the array (horizontal blanking) return zero.
    always_ff @(posedge clk) begin
        if (we && (wr_addr <= LAST)) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_addr <= LAST) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/text_fetch.sv
// rtl/text_fetch.sv - pixel counters to character code, glyph position and colors
module text_fetch
    import ogege_pkg::*;
#(
    parameter int          HSZ        = 10,
    parameter int          VSZ        = 9,
    parameter int          COLS       = COLS_DEFAULT,
    parameter int          ROWS       = ROWS_DEFAULT,
    parameter logic [15:0] CLEAR_WORD = CLEAR_WORD_DEFAULT
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [HSZ-1:0] i_hcount,
    input  logic [VSZ-1:0] i_vcount,
    input  logic           i_de,
    input  logic           i_hsync,
    input  logic           i_vsync,
    input  logic           i_wr_valid,
    output logic           o_wr_ready,
    input  logic           i_wr_sel,
    input  logic [12:0]    i_wr_addr,
    input  logic [15:0]    i_wr_data,
    output logic [7:0]     o_char,
    output logic [2:0]     o_row,
    output logic [2:0]     o_column,
    output logic [11:0]    o_fg_color,
    output logic [11:0]    o_bg_color,
    output logic           o_de,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_busy
);

    localparam int                 CELLS     = COLS * ROWS;
    localparam logic [ADDR_W-1:0]  LAST_CELL = ADDR_W'(CELLS - 1);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] clr_cnt, clr_n;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata;
    logic              pal_we;

    logic [11:0]       palette [16];

    logic [ADDR_W-1:0] cell_row, cell_col, cell_addr;
    logic [ADDR_W-1:0] s1_addr;
    logic [2:0]        s1_row, s1_col, s2_row, s2_col;
    logic              s1_de, s1_hs, s1_vs, s2_de, s2_hs, s2_vs;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_n;
            clr_cnt <= clr_n;
        end
    end

    always_comb begin
        state_n    = state;
        clr_n      = clr_cnt;
        o_busy     = 1'b0;
        o_wr_ready = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = i_wr_addr;
        ram_wdata  = i_wr_data;
        pal_we     = 1'b0;
        case (state)
            ST_CLEAR: begin
                o_busy    = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = clr_cnt;
                ram_wdata = CLEAR_WORD;
                clr_n     = clr_cnt + ADDR_W'(1);
                if (clr_cnt == LAST_CELL) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                o_wr_ready = 1'b1;
                if (i_wr_valid) begin
                    pal_we = i_wr_sel;
                    // Out-of-range text writes are accepted but dropped here.
                    ram_we = !i_wr_sel && (i_wr_addr <= LAST_CELL);
                end
            end
        endcase
        if (rst_i) begin
            o_busy     = 1'b1;
            o_wr_ready = 1'b0;
            ram_we     = 1'b0;
            pal_we     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) begin
                palette[i] <= palette_reset(4'(i));
            end
        end else if (pal_we) begin
            palette[i_wr_addr[3:0]] <= i_wr_data[11:0];
        end
    end

    text_ram #(
        .DEPTH (CELLS),
        .AW    (ADDR_W),
        .DW    (16)
    ) u_text_ram (
        .clk     (clk_i),
        .we      (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (s1_addr),
        .rd_data (ram_rdata)
    );

    assign cell_row  = ADDR_W'(i_vcount[VSZ-1:3]);
    assign cell_col  = ADDR_W'(i_hcount[HSZ-1:3]);
    assign cell_addr = cell_row * ADDR_W'(COLS) + cell_col;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_addr <= '0;
            s1_row  <= '0;
            s1_col  <= '0;
            s1_de   <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s2_row  <= '0;
            s2_col  <= '0;
            s2_de   <= 1'b0;
            s2_hs   <= 1'b0;
            s2_vs   <= 1'b0;
        end else begin
            s1_addr <= cell_addr;
            s1_row  <= i_vcount[2:0];
            s1_col  <= i_hcount[2:0];
            s1_de   <= i_de;
            s1_hs   <= i_hsync;
            s1_vs   <= i_vsync;
            s2_row  <= s1_row;
            s2_col  <= s1_col;
            s2_de   <= s1_de;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
        end
    end

    // Blanked pixels force content to zero so nothing undefined leaves the stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            o_char     <= '0;
            o_row      <= '0;
            o_column   <= '0;
            o_fg_color <= '0;
            o_bg_color <= '0;
            o_de       <= 1'b0;
            o_hsync    <= 1'b0;
            o_vsync    <= 1'b0;
        end else begin
            o_row    <= s2_row;
            o_column <= s2_col;
            o_de     <= s2_de;
            o_hsync  <= s2_hs;
            o_vsync  <= s2_vs;
            if (s2_de) begin
                o_char     <= ram_rdata[CHAR_LSB +: 8];
                o_fg_color <= palette[ram_rdata[FG_LSB +: 4]];
                o_bg_color <= palette[ram_rdata[BG_LSB +: 4]];
            end else begin
                o_char     <= '0;
                o_fg_color <= '0;
                o_bg_color <= '0;
            end
        end
    end

endmodule

// File: tb/tb_text_fetch.sv
// tb/tb_text_fetch.sv - directed self-checking bench for text_fetch
module tb_text_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [9:0]  i_hcount;
    logic [8:0]  i_vcount;
    logic        i_de, i_hsync, i_vsync;
    logic        i_wr_valid, o_wr_ready, i_wr_sel;
    logic [12:0] i_wr_addr;
    logic [15:0] i_wr_data;
    logic [7:0]  o_char;
    logic [2:0]  o_row, o_column;
    logic [11:0] o_fg_color, o_bg_color;
    logic        o_de, o_hsync, o_vsync, o_busy;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [9:0]  h;
        logic [8:0]  v;
        logic        de, hs, vs;
        logic        wv, ws;
        logic [12:0] wa;
        logic [15:0] wd;
        logic        chk;
        logic [7:0]  ch;
        logic [11:0] fg, bg;
    } vec_t;

    vec_t vq[$];

    text_fetch dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_hcount   (i_hcount),
        .i_vcount   (i_vcount),
        .i_de       (i_de),
        .i_hsync    (i_hsync),
        .i_vsync    (i_vsync),
        .i_wr_valid (i_wr_valid),
        .o_wr_ready (o_wr_ready),
        .i_wr_sel   (i_wr_sel),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .o_char     (o_char),
        .o_row      (o_row),
        .o_column   (o_column),
        .o_fg_color (o_fg_color),
        .o_bg_color (o_bg_color),
        .o_de       (o_de),
        .o_hsync    (o_hsync),
        .o_vsync    (o_vsync),
        .o_busy     (o_busy)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_vec(input int h, input int v, input logic de, input logic hs, input logic vs,
                           input logic wv, input logic ws, input int wa, input logic [15:0] wd,
                           input logic chk, input logic [7:0] ch, input logic [11:0] fg,
                           input logic [11:0] bg);
        vec_t e;
        e.h = 10'(h); e.v = 9'(v); e.de = de; e.hs = hs; e.vs = vs;
        e.wv = wv; e.ws = ws; e.wa = 13'(wa); e.wd = wd;
        e.chk = chk; e.ch = ch; e.fg = fg; e.bg = bg;
        vq.push_back(e);
    endtask

    task automatic add_px(input int h, input int v, input logic [7:0] ch,
                          input logic [11:0] fg, input logic [11:0] bg);
        add_vec(h, v, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0, 1'b1, ch, fg, bg);
    endtask

    task automatic drive_idle();
        i_de = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0;
        i_hcount = '0; i_vcount = '0;
        i_wr_valid = 1'b0; i_wr_sel = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    endtask

    // Vector k is driven at negedge k; its result is sampled at negedge k+3.
    task automatic run_vecs();
        vec_t e;
        int n;
        n = vq.size();
        for (int k = 0; k < n + 3; k++) begin
            @(negedge clk_i);
            if (k >= 3) begin
                e = vq[k-3];
                check_eq("de", 32'(o_de), 32'(e.de));
                check_eq("hsync", 32'(o_hsync), 32'(e.hs));
                check_eq("vsync", 32'(o_vsync), 32'(e.vs));
                if (e.de) begin
                    check_eq("row", 32'(o_row), 32'(e.v[2:0]));
                    check_eq("column", 32'(o_column), 32'(e.h[2:0]));
                    if (e.chk) begin
                        check_eq("char", 32'(o_char), 32'(e.ch));
                        check_eq("fg", 32'(o_fg_color), 32'(e.fg));
                        check_eq("bg", 32'(o_bg_color), 32'(e.bg));
                    end
                end
            end
            if (k < n) begin
                e = vq[k];
                i_hcount = e.h; i_vcount = e.v;
                i_de = e.de; i_hsync = e.hs; i_vsync = e.vs;
                i_wr_valid = e.wv; i_wr_sel = e.ws; i_wr_addr = e.wa; i_wr_data = e.wd;
            end else begin
                drive_idle();
            end
        end
        vq.delete();
    endtask

    // Called at the negedge where rst_i has just been released.
    task automatic count_busy(output int n);
        int bad;
        n = 0;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            if (!o_busy) break;
            if (o_wr_ready) bad++;
            n++;
            @(negedge clk_i);
        end
        check_eq("ready_while_busy", 32'(bad), 32'd0);
        check_eq("ready_after_clear", 32'(o_wr_ready), 32'd1);
    endtask

    initial begin
        int n;
        drive_idle();
        rst_i = 1'b1;
        i_de = 1'b1; i_hsync = 1'b1; i_vsync = 1'b1; i_hcount = 10'd13; i_vcount = 9'd6;
        repeat (3) @(negedge clk_i);
        check_eq("rst_busy", 32'(o_busy), 32'd1);
        check_eq("rst_ready", 32'(o_wr_ready), 32'd0);
        check_eq("rst_char", 32'(o_char), 32'd0);
        check_eq("rst_row", 32'(o_row), 32'd0);
        check_eq("rst_column", 32'(o_column), 32'd0);
        check_eq("rst_fg", 32'(o_fg_color), 32'd0);
        check_eq("rst_bg", 32'(o_bg_color), 32'd0);
        check_eq("rst_de", 32'(o_de), 32'd0);
        check_eq("rst_hsync", 32'(o_hsync), 32'd0);
        check_eq("rst_vsync", 32'(o_vsync), 32'd0);
        drive_idle();
        rst_i = 1'b0;
        count_busy(n);
        check_eq("clear_len", 32'(n), 32'd4800);

        // Cleared screen: corners and middle.
        add_vec(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 16'h0, 1'b1, 8'h20, 12'hFFF, 12'h008);
        add_vec(632, 472, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0, 1'b1, 8'h20, 12'hFFF, 12'h008);
        add_px(639, 479, 8'h20, 12'hFFF, 12'h008);
        add_px(320, 240, 8'h20, 12'hFFF, 12'h008);
        run_vecs();

        // Cell 81 write, read back on the very next pixel.
        add_vec(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 81, 16'h2F41, 1'b0, 8'h0, 12'h0, 12'h0);
        for (int i = 0; i < 8; i++) add_px(8 + i, 8 + i, 8'h41, 12'hFFF, 12'h000);
        run_vecs();

        // Palette write lands on the lookup of the first pixel: old, then new.
        add_px(8, 8, 8'h41, 12'hFFF, 12'h000);
        add_px(9, 9, 8'h41, 12'hFFF, 12'hF00);
        add_vec(10, 10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2, 16'h0F00, 1'b1, 8'h41, 12'hFFF, 12'hF00);
        add_px(11, 11, 8'h41, 12'hFFF, 12'hF00);
        run_vecs();

        // Timing stream alignment.
        for (int i = 0; i < 40; i++) begin
            add_vec(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 16'h0, 1'b1,
                    8'h20, 12'hFFF, 12'h008);
        end
        run_vecs();

        // Reset in the middle of a clear.
        @(negedge clk_i);
        i_hcount = 10'd5; i_vcount = 9'd3; i_de = 1'b1; i_hsync = 1'b1; i_vsync = 1'b0;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2000) @(negedge clk_i);
        check_eq("mid_busy", 32'(o_busy), 32'd1);
        check_eq("mid_de", 32'(o_de), 32'd1);
        check_eq("mid_row", 32'(o_row), 32'd3);
        check_eq("mid_column", 32'(o_column), 32'd5);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_eq("mid_rst_de", 32'(o_de), 32'd0);
        check_eq("mid_rst_hsync", 32'(o_hsync), 32'd0);
        check_eq("mid_rst_column", 32'(o_column), 32'd0);
        check_eq("mid_rst_busy", 32'(o_busy), 32'd1);
        check_eq("mid_rst_ready", 32'(o_wr_ready), 32'd0);
        drive_idle();
        @(negedge clk_i);
        rst_i = 1'b0;
        count_busy(n);
        check_eq("reclear_len", 32'(n), 32'd4800);

        // Out-of-range text write is dropped; cells and palette back to defaults.
        check_eq("ready_5000", 32'(o_wr_ready), 32'd1);
        add_vec(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5000, 16'hABCD, 1'b0, 8'h0, 12'h0, 12'h0);
        add_px(0, 0, 8'h20, 12'hFFF, 12'h008);
        add_px(192, 88, 8'h20, 12'hFFF, 12'h008);
        add_px(320, 16, 8'h20, 12'hFFF, 12'h008);
        add_px(632, 472, 8'h20, 12'hFFF, 12'h008);
        add_px(8, 8, 8'h20, 12'hFFF, 12'h008);
        run_vecs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
